// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : shared states, frame timing and byte selection for the I2C master
// rev 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      ACK   = 3'd3,
      STOP  = 3'd4,
      HOLD  = 3'd5
   } state_t;

   localparam int START_TICKS = 2;
   localparam int STOP_TICKS  = 3;
   localparam int HOLD_TICKS  = 4;
   localparam int BIT_TICKS   = 4;
   localparam int NUM_BYTES   = 3;

   // Frame byte order: {addr, rw}, payload high byte, payload low byte.
   function automatic logic [7:0] frame_byte(input logic [7:0]  addr_rw,
                                             input logic [15:0] data,
                                             input logic [1:0]  idx);
      case (idx)
         2'd0:    return addr_rw;
         2'd1:    return data[15:8];
         default: return data[7:0];
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_write_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_write_master_if : request/status handshake between sequencer and master
// rev 1.0
// ----------------------------------------------------------------------------
interface i2c_write_master_if;
   logic        ena;
   logic [6:0]  addr;
   logic        rw;
   logic [15:0] data_wr;
   logic        busy;
   logic        ack_error;

   // master = requesting sequencer, slave = the I2C engine serving it
   modport master (output ena, addr, rw, data_wr, input  busy, ack_error);
   modport slave  (input  ena, addr, rw, data_wr, output busy, ack_error);
endinterface
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_tick_gen : CLK_DIV divider producing a 1-cycle quarter-bit tick strobe
// rev 1.0
// ----------------------------------------------------------------------------
module i2c_tick_gen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   output logic o_tick
);
   localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_restart || r_cnt == c_LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   assign o_tick = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/i2c_write_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_write_master : byte-level write-oriented I2C master (START/3 bytes/STOP)
// rev 1.0
// ----------------------------------------------------------------------------
module i2c_write_master #(
   parameter int CLK_DIV = 1
) (
   input  logic              clock,
   input  logic              reset,
   i2c_write_master_if.slave bus,
   inout  wire               sda,
   output logic              scl
);
   import i2c_pkg::*;

   state_t      r_state, w_state_nx;
   logic        w_tick, w_accept, w_last_byte, w_scl, w_sda_low, w_sda_in;
   logic [1:0]  r_qtr, r_byte;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift, r_addr_rw;
   logic [15:0] r_data;
   logic        r_ack_error;

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk       (clock),
      .rst       (reset),
      .i_restart (w_accept),
      .o_tick    (w_tick)
   );

   // An address-only probe ends after the first byte.
   assign w_last_byte = r_addr_rw[0] ? (r_byte == 2'd0) : (r_byte == 2'(NUM_BYTES - 1));

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_scl      = 1'b1;
      w_sda_low  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.ena) begin
               w_accept   = 1'b1;
               w_state_nx = START;
            end
         end
         START: begin
            w_sda_low = 1'b1;
            w_scl     = (r_qtr == 2'd0);
            if (w_tick && r_qtr == 2'(START_TICKS - 1)) w_state_nx = DATA;
         end
         DATA: begin
            w_sda_low = ~r_shift[7];
            w_scl     = (r_qtr == 2'd1) || (r_qtr == 2'd2);
            if (w_tick && r_qtr == 2'(BIT_TICKS - 1) && r_bit == 3'd7) w_state_nx = ACK;
         end
         ACK: begin
            w_scl = (r_qtr == 2'd1) || (r_qtr == 2'd2);
            if (w_tick && r_qtr == 2'(BIT_TICKS - 1))
               w_state_nx = (r_ack_error || w_last_byte) ? STOP : DATA;
         end
         STOP: begin
            w_sda_low = (r_qtr != 2'd2);
            w_scl     = (r_qtr != 2'd0);
            if (w_tick && r_qtr == 2'(STOP_TICKS - 1)) w_state_nx = HOLD;
         end
         HOLD: begin
            if (w_tick && r_qtr == 2'(HOLD_TICKS - 1)) w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_qtr       <= '0;
         r_bit       <= '0;
         r_byte      <= '0;
         r_shift     <= '0;
         r_addr_rw   <= '0;
         r_data      <= '0;
         r_ack_error <= 1'b0;
      end else begin
         if (w_state_nx != r_state)
            r_qtr <= '0;
         else if (w_tick && r_state != IDLE)
            r_qtr <= r_qtr + 2'd1;

         if (w_accept) begin
            r_addr_rw   <= {bus.addr, bus.rw};
            r_data      <= bus.data_wr;
            r_shift     <= {bus.addr, bus.rw};
            r_bit       <= '0;
            r_byte      <= '0;
            r_ack_error <= 1'b0;
         end

         if (r_state == DATA && w_tick && r_qtr == 2'(BIT_TICKS - 1)) begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {r_shift[6:0], 1'b0};
         end

         // Slave's answer is sampled at the end of the second high quarter.
         if (r_state == ACK && w_tick) begin
            if (r_qtr == 2'd2 && w_sda_in)
               r_ack_error <= 1'b1;
            if (r_qtr == 2'(BIT_TICKS - 1) && !r_ack_error && !w_last_byte) begin
               r_byte  <= r_byte + 2'd1;
               r_shift <= frame_byte(r_addr_rw, r_data, r_byte + 2'd1);
            end
         end
      end
   end

   assign sda           = w_sda_low ? 1'b0 : 1'bz;
   assign w_sda_in      = sda;
   assign scl           = w_scl;
   assign bus.busy      = (r_state != IDLE);
   assign bus.ack_error = r_ack_error;
endmodule
`default_nettype wire

// File: tb/tb_i2c_write_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_write_master : directed bench with an open-drain slave bus model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_i2c_write_master;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   wire sda;
   wire scl_a, scl_b;
   pullup (sda);

   i2c_write_master_if bus_a ();
   i2c_write_master_if bus_b ();

   i2c_write_master #(.CLK_DIV(1)) dut_a (
      .clock (clock), .reset (reset), .bus (bus_a), .sda (sda), .scl (scl_a)
   );
   i2c_write_master #(.CLK_DIV(4)) dut_b (
      .clock (clock), .reset (reset), .bus (bus_b), .sda (sda), .scl (scl_b)
   );

   // Slave model watching whichever master is selected; both share one SDA wire.
   logic       sel      = 1'b0;
   int         nack_idx = -1;
   logic       sl_drive = 1'b0;
   logic       p_scl = 1'b1, p_sda = 1'b1, s_scl, s_sda, acking = 1'b0;
   logic [7:0] sh = 8'h00;
   int         bitcnt = 0, bytenum = 0, starts = 0, stops = 0;
   logic [7:0] q[$];

   assign sda = sl_drive ? 1'b0 : 1'bz;

   always @(negedge clock) begin
      s_scl = sel ? scl_b : scl_a;
      s_sda = sda;
      if (p_scl && s_scl && p_sda && !s_sda) begin
         starts++; bitcnt = 0; bytenum = 0; acking = 1'b0; sl_drive = 1'b0;
      end else if (p_scl && s_scl && !p_sda && s_sda) begin
         stops++;
      end else if (!p_scl && s_scl) begin
         if (bitcnt < 8) begin
            sh = {sh[6:0], s_sda};
            bitcnt++;
            if (bitcnt == 8) q.push_back(sh);
         end
      end else if (p_scl && !s_scl) begin
         if (bitcnt == 8 && !acking) begin
            acking = 1'b1; sl_drive = (bytenum != nack_idx);
         end else if (acking) begin
            acking = 1'b0; sl_drive = 1'b0; bitcnt = 0; bytenum++;
         end
      end
      p_scl = s_scl;
      p_sda = s_sda;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
      logic [31:0] obs;
      obs = (idx < q.size()) ? {24'h0, q[idx]} : 32'hDEAD;
      chk(tag, obs, {24'h0, exp});
   endtask

   task automatic txn_a(input logic [6:0] ad, input logic rw, input logic [15:0] d,
                        input int nk, output int ncyc, output logic ae_start);
      @(negedge clock);
      nack_idx      = nk;
      bus_a.addr    = ad;
      bus_a.rw      = rw;
      bus_a.data_wr = d;
      bus_a.ena     = 1'b1;
      @(negedge clock);
      bus_a.ena = 1'b0;
      ae_start  = bus_a.ack_error;
      ncyc      = 0;
      while (bus_a.busy && ncyc < 1000) begin
         ncyc++;
         @(negedge clock);
      end
   endtask

   int   qb, sb, pb, n, n2, gap, w;
   logic ae;

   initial begin
      bus_a.ena = 1'b0; bus_a.addr = '0; bus_a.rw = 1'b0; bus_a.data_wr = '0;
      bus_b.ena = 1'b0; bus_b.addr = '0; bus_b.rw = 1'b0; bus_b.data_wr = '0;

      // Reset state
      repeat (10) @(negedge clock);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_ackerr", bus_a.ack_error, 0);
      chk("rst_scl", scl_a, 1);
      chk("rst_sda", sda, 1);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("idle_busy", bus_a.busy, 0);

      // Full write, all ACKed
      qb = q.size(); sb = starts; pb = stops;
      txn_a(7'h1A, 1'b0, 16'h0E02, -1, n, ae);
      chk("wr_busy_cycles", n, 117);
      chk("wr_ackerr", bus_a.ack_error, 0);
      chk("wr_nbytes", q.size() - qb, 3);
      chk_byte("wr_byte0", qb, 8'h34);
      chk_byte("wr_byte1", qb + 1, 8'h0E);
      chk_byte("wr_byte2", qb + 2, 8'h02);
      chk("wr_starts", starts - sb, 1);
      chk("wr_stops", stops - pb, 1);

      // Address NACK
      qb = q.size(); pb = stops;
      txn_a(7'h1A, 1'b0, 16'h0E02, 0, n, ae);
      chk("anack_busy_cycles", n, 45);
      chk("anack_ackerr", bus_a.ack_error, 1);
      chk("anack_nbytes", q.size() - qb, 1);
      chk_byte("anack_byte0", qb, 8'h34);
      chk("anack_stops", stops - pb, 1);
      repeat (5) @(negedge clock);
      chk("anack_ackerr_held", bus_a.ack_error, 1);

      // NACK on the last data byte
      qb = q.size();
      txn_a(7'h55, 1'b0, 16'hA5C3, 2, n, ae);
      chk("dnack_ackerr_cleared", ae, 0);
      chk("dnack_busy_cycles", n, 117);
      chk("dnack_ackerr", bus_a.ack_error, 1);
      chk_byte("dnack_byte0", qb, 8'hAA);
      chk_byte("dnack_byte1", qb + 1, 8'hA5);
      chk_byte("dnack_byte2", qb + 2, 8'hC3);

      // Address-only probe
      qb = q.size(); pb = stops;
      txn_a(7'h1A, 1'b1, 16'hFFFF, -1, n, ae);
      chk("probe_busy_cycles", n, 45);
      chk("probe_ackerr", bus_a.ack_error, 0);
      chk("probe_nbytes", q.size() - qb, 1);
      chk_byte("probe_byte0", qb, 8'h35);
      chk("probe_stops", stops - pb, 1);

      // CLK_DIV=4, ena held across two frames, payload changed mid-frame
      @(negedge clock);
      sel = 1'b1; nack_idx = -1;
      qb = q.size(); sb = starts; pb = stops;
      bus_b.addr = 7'h1A; bus_b.rw = 1'b0; bus_b.data_wr = 16'h1234; bus_b.ena = 1'b1;
      w = 0;
      while (!bus_b.busy && w < 20) begin
         @(negedge clock);
         w++;
      end
      n = 0;
      while (bus_b.busy && n < 3000) begin
         n++;
         if (n == 100) bus_b.data_wr = 16'hBEEF;
         @(negedge clock);
      end
      gap = 0;
      while (!bus_b.busy && gap < 50) begin
         gap++;
         @(negedge clock);
      end
      bus_b.ena = 1'b0;
      n2 = 0;
      while (bus_b.busy && n2 < 3000) begin
         n2++;
         @(negedge clock);
      end
      chk("div4_busy1", n, 468);
      chk("div4_gap", gap, 1);
      chk("div4_busy2", n2, 468);
      chk("div4_ackerr", bus_b.ack_error, 0);
      chk("div4_nbytes", q.size() - qb, 6);
      chk_byte("div4_f1_b0", qb, 8'h34);
      chk_byte("div4_f1_b1", qb + 1, 8'h12);
      chk_byte("div4_f1_b2", qb + 2, 8'h34);
      chk_byte("div4_f2_b0", qb + 3, 8'h34);
      chk_byte("div4_f2_b1", qb + 4, 8'hBE);
      chk_byte("div4_f2_b2", qb + 5, 8'hEF);
      chk("div4_starts", starts - sb, 2);
      chk("div4_stops", stops - pb, 2);

      // Reset during data byte 1, then a normal request
      @(negedge clock);
      sel = 1'b0; nack_idx = -1;
      qb = q.size();
      bus_a.addr = 7'h1A; bus_a.rw = 1'b0; bus_a.data_wr = 16'h0E02; bus_a.ena = 1'b1;
      @(negedge clock);
      bus_a.ena = 1'b0;
      w = 0;
      while (!(q.size() == qb + 1 && bitcnt == 3) && w < 500) begin
         @(negedge clock);
         w++;
      end
      chk("mid_reached", (w < 500), 1);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_busy", bus_a.busy, 0);
      chk("mid_rst_scl", scl_a, 1);
      chk("mid_rst_sda", sda, 1);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      qb = q.size();
      txn_a(7'h1A, 1'b0, 16'h0E02, -1, n, ae);
      chk("post_busy_cycles", n, 117);
      chk("post_ackerr", bus_a.ack_error, 0);
      chk_byte("post_byte0", qb, 8'h34);
      chk_byte("post_byte1", qb + 1, 8'h0E);
      chk_byte("post_byte2", qb + 2, 8'h02);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
